// File: rtl/op_pkg.sv
// Shared front-end widths used as defaults by the fetch/decode blocks.
package op_pkg;

  localparam int unsigned SUPER_SCALAR_WIDTH = 4;
  localparam int unsigned INSTRUCTION_WIDTH  = 32;

endpackage

// File: rtl/fetch_instr_queue.sv
// Bundle FIFO between fetch and decode with one-cycle flush and a per-lane valid mask.
// Optional macro FETCH_IQ_NOP_SQUASH_EN: also invalidate lanes holding the fetch NOP filler.
module fetch_instr_queue #(
  parameter int unsigned SUPER_SCALAR_WIDTH = op_pkg::SUPER_SCALAR_WIDTH,
  parameter int unsigned INSTRUCTION_WIDTH  = op_pkg::INSTRUCTION_WIDTH,
  parameter int unsigned CACHE_LINE_WIDTH   = 64,
  parameter int unsigned DEPTH              = 4
) (
  input  logic                                                  clk_in,
  input  logic                                                  rst_in,
  input  logic                                                  flush_in,
  input  logic                                                  enq_valid,
  input  logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0]  enq_instrs,
  input  logic [63:0]                                           enq_pc,
  output logic                                                  enq_ready,
  output logic                                                  deq_valid,
  output logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0]  deq_instrs,
  output logic [63:0]                                           deq_pc,
  output logic [SUPER_SCALAR_WIDTH-1:0]                         deq_lane_mask,
  input  logic                                                  deq_ready,
  output logic [$clog2(DEPTH+1)-1:0]                            count_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OFF_W = $clog2(CACHE_LINE_WIDTH);
  localparam int unsigned SUM_W = OFF_W + $clog2(SUPER_SCALAR_WIDTH) + 3;
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  typedef struct packed {
    logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] instrs;
    logic [63:0]                                          pc;
    logic [SUPER_SCALAR_WIDTH-1:0]                        lane_mask;
  } entry_t;

  entry_t             entries [DEPTH];
  logic [PTR_W-1:0]   head_ptr;
  logic [PTR_W-1:0]   tail_ptr;
  logic [CNT_W-1:0]   count;
  logic [OFF_W-1:0]   line_off;
  logic [SUM_W-1:0]   lane_end;
  logic [SUPER_SCALAR_WIDTH-1:0] enq_lane_mask;
  logic               enq_fire;
  logic               deq_fire;

  assign enq_ready = !rst_in && (count < CNT_W'(DEPTH));
  assign deq_valid = (count != '0);
  assign count_out = count;
  assign enq_fire  = enq_valid && enq_ready && !flush_in;
  assign deq_fire  = deq_valid && deq_ready && !flush_in;

  assign deq_instrs    = entries[head_ptr].instrs;
  assign deq_pc        = entries[head_ptr].pc;
  assign deq_lane_mask = entries[head_ptr].lane_mask;

  assign line_off = enq_pc[OFF_W-1:0];

  // A lane is valid only if its whole 4-byte instruction lies inside the current line.
  always_comb begin
    enq_lane_mask = '0;
    lane_end      = '0;
    for (int unsigned i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
      lane_end = SUM_W'(line_off) + SUM_W'(4 * i) + SUM_W'(3);
      enq_lane_mask[i] = (lane_end < SUM_W'(CACHE_LINE_WIDTH));
`ifdef FETCH_IQ_NOP_SQUASH_EN
      if (enq_instrs[i] == INSTRUCTION_WIDTH'(NOP_INSTR)) begin
        enq_lane_mask[i] = 1'b0;
      end
`endif
    end
  end

  // Entry storage; contents are cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (enq_fire) begin
      entries[tail_ptr] <= '{instrs: enq_instrs, pc: enq_pc, lane_mask: enq_lane_mask};
    end
  end

  // Pointers and occupancy; flush wins over any same-cycle enqueue or dequeue.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush_in) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (enq_fire) begin
        tail_ptr <= tail_ptr + PTR_W'(1);
      end
      if (deq_fire) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Directed self-checking bench for fetch_instr_queue (DEPTH=4, 4 lanes, 64-byte lines).
module tb_fetch_instr_queue;

  typedef logic [3:0][31:0] bundle_t;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        flush_in;
  logic        enq_valid;
  bundle_t     enq_instrs;
  logic [63:0] enq_pc;
  logic        enq_ready;
  logic        deq_valid;
  bundle_t     deq_instrs;
  logic [63:0] deq_pc;
  logic [3:0]  deq_lane_mask;
  logic        deq_ready;
  logic [2:0]  count_out;

  int total = 0;
  int bad   = 0;

  fetch_instr_queue #(
    .SUPER_SCALAR_WIDTH(4),
    .INSTRUCTION_WIDTH (32),
    .CACHE_LINE_WIDTH  (64),
    .DEPTH             (4)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .flush_in     (flush_in),
    .enq_valid    (enq_valid),
    .enq_instrs   (enq_instrs),
    .enq_pc       (enq_pc),
    .enq_ready    (enq_ready),
    .deq_valid    (deq_valid),
    .deq_instrs   (deq_instrs),
    .deq_pc       (deq_pc),
    .deq_lane_mask(deq_lane_mask),
    .deq_ready    (deq_ready),
    .count_out    (count_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic bundle_t mk(input logic [63:0] pc);
    bundle_t b;
    for (int i = 0; i < 4; i++) begin
      b[i] = {pc[15:0], 16'(i)};
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic offer(input logic v, input logic [63:0] pc);
    enq_valid  = v;
    enq_pc     = pc;
    enq_instrs = mk(pc);
  endtask

  bundle_t nop_b;

  initial begin
    rst_in = 1'b1; flush_in = 1'b0; deq_ready = 1'b0;
    offer(1'b0, 64'h0);

    // Reset held for three cycles
    repeat (3) tick();
    chk("rst_deq_valid", 128'(deq_valid), 128'(0));
    chk("rst_count", 128'(count_out), 128'(0));
    chk("rst_enq_ready", 128'(enq_ready), 128'(0));
    chk("rst_deq_pc", 128'(deq_pc), 128'(0));
    chk("rst_deq_instrs", 128'(deq_instrs), 128'(0));
    chk("rst_deq_mask", 128'(deq_lane_mask), 128'(0));
    rst_in = 1'b0;
    #1;
    chk("rel_enq_ready", 128'(enq_ready), 128'(1));
    chk("rel_deq_valid", 128'(deq_valid), 128'(0));

    // Fill with decode stalled
    offer(1'b1, 64'h1000); tick();
    chk("fill1_count", 128'(count_out), 128'(1));
    chk("fill1_deq_valid", 128'(deq_valid), 128'(1));
    chk("fill1_pc", 128'(deq_pc), 128'(64'h1000));
    chk("fill1_mask", 128'(deq_lane_mask), 128'(4'b1111));
    chk("fill1_instrs", 128'(deq_instrs), 128'(mk(64'h1000)));
    offer(1'b1, 64'h1010); tick();
    offer(1'b1, 64'h1020); tick();
    offer(1'b1, 64'h1030); tick();
    chk("full_count", 128'(count_out), 128'(4));
    chk("full_enq_ready", 128'(enq_ready), 128'(0));
    offer(1'b1, 64'h1040); tick();
    chk("full_refuse_count", 128'(count_out), 128'(4));
    chk("full_hold_pc", 128'(deq_pc), 128'(64'h1000));

    // Drain in order
    offer(1'b0, 64'h0);
    deq_ready = 1'b1;
    tick(); chk("drain_pc1", 128'(deq_pc), 128'(64'h1010));
    tick(); chk("drain_pc2", 128'(deq_pc), 128'(64'h1020));
    tick(); chk("drain_pc3", 128'(deq_pc), 128'(64'h1030));
    chk("drain_instrs3", 128'(deq_instrs), 128'(mk(64'h1030)));
    tick();
    chk("drained_valid", 128'(deq_valid), 128'(0));
    chk("drained_count", 128'(count_out), 128'(0));

    // Two entries, then simultaneous enq/deq for six cycles
    deq_ready = 1'b0;
    offer(1'b1, 64'h2000); tick();
    offer(1'b1, 64'h2010); tick();
    chk("pre_sim_count", 128'(count_out), 128'(2));
    deq_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      offer(1'b1, 64'h2020 + 64'(16 * k)); tick();
      chk($sformatf("sim_count%0d", k), 128'(count_out), 128'(2));
      chk($sformatf("sim_pc%0d", k), 128'(deq_pc), 128'(64'h2010 + 64'(16 * k)));
    end

    // Grow to three, then flush with enq and deq both requested
    deq_ready = 1'b0;
    offer(1'b1, 64'h2080); tick();
    chk("pre_flush_count", 128'(count_out), 128'(3));
    flush_in = 1'b1; deq_ready = 1'b1;
    offer(1'b1, 64'h3000); tick();
    flush_in = 1'b0;
    chk("flush_count", 128'(count_out), 128'(0));
    chk("flush_deq_valid", 128'(deq_valid), 128'(0));
    chk("flush_enq_ready", 128'(enq_ready), 128'(1));
    deq_ready = 1'b0;
    offer(1'b1, 64'h3010); tick();
    chk("post_flush_count", 128'(count_out), 128'(1));
    chk("post_flush_pc", 128'(deq_pc), 128'(64'h3010));
    offer(1'b0, 64'h0); deq_ready = 1'b1; tick();
    chk("post_flush_sole", 128'(deq_valid), 128'(0));

    // Lane masks near the end of a line
    deq_ready = 1'b0;
    offer(1'b1, 64'h103C); tick();
    chk("mask_103c", 128'(deq_lane_mask), 128'(4'b0001));
    deq_ready = 1'b1;
    offer(1'b1, 64'h1034); tick();
    chk("mask_1034", 128'(deq_lane_mask), 128'(4'b0111));
    nop_b = mk(64'h1000);
    nop_b[2] = 32'hD503201F;
    enq_valid = 1'b1; enq_pc = 64'h1000; enq_instrs = nop_b;
    tick();
    chk("nop_instrs", 128'(deq_instrs), 128'(nop_b));
`ifdef FETCH_IQ_NOP_SQUASH_EN
    chk("nop_mask", 128'(deq_lane_mask), 128'(4'b1011));
`else
    chk("nop_mask", 128'(deq_lane_mask), 128'(4'b1111));
`endif

    // Async reset between edges at count 3
    deq_ready = 1'b0;
    offer(1'b1, 64'h5000); tick();
    offer(1'b1, 64'h5010); tick();
    offer(1'b0, 64'h0);
    chk("pre_arst_count", 128'(count_out), 128'(3));
    #2;
    rst_in = 1'b1;
    #1;
    chk("arst_deq_valid", 128'(deq_valid), 128'(0));
    chk("arst_count", 128'(count_out), 128'(0));
    chk("arst_enq_ready", 128'(enq_ready), 128'(0));
    chk("arst_deq_pc", 128'(deq_pc), 128'(0));
    tick();
    rst_in = 1'b0;
    #1;
    chk("arst_rel_ready", 128'(enq_ready), 128'(1));
    chk("arst_rel_count", 128'(count_out), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
